// File: rtl/dispatch_queue_pkg.sv
// Shared definitions for the dispatch queue and the rename stage.
package dispatch_queue_pkg;

  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam int unsigned DqAddrWidth = 32;

  typedef struct packed {
    logic [31:0]            inst;
    logic [DqAddrWidth-1:0] pc;
    logic                   has_dest;
  } dq_entry_t;

  // Only the low 12 bits (rd and opcode) decide whether a register is written.
  function automatic logic decode_has_dest(input logic [11:0] inst_lo);
    return (inst_lo[11:7] != 5'd0) && (inst_lo[6:0] != OPC_STORE) &&
           (inst_lo[6:0] != OPC_BRANCH);
  endfunction

endpackage

// File: rtl/dispatch_queue_if.sv
// Fetch-side and dispatch-side signal bundle of the dispatch queue.
interface dispatch_queue_if #(
  parameter int unsigned FetchWidth    = 2,
  parameter int unsigned DispatchWidth = 2,
  parameter int unsigned QDepth        = 8,
  parameter int unsigned AddrWidth     = 32
);
  localparam int unsigned FreeW = $clog2(DispatchWidth + 1);
  localparam int unsigned CntW  = $clog2(QDepth + 1);

  logic [FetchWidth-1:0]                   fetch_valid_i;
  logic [FetchWidth-1:0][31:0]             fetch_inst_i;
  logic [FetchWidth-1:0][AddrWidth-1:0]    fetch_pc_i;
  logic                                    fetch_ready_o;
  logic [FreeW-1:0]                        free_regs_i;
  logic [FreeW-1:0]                        free_rs_slots_i;
  logic [FreeW-1:0]                        free_rob_slots_i;
  logic                                    flush_i;
  logic [DispatchWidth-1:0]                disp_valid_o;
  logic [DispatchWidth-1:0][31:0]          disp_inst_o;
  logic [DispatchWidth-1:0][AddrWidth-1:0] disp_pc_o;
  logic [DispatchWidth-1:0]                disp_has_dest_o;
  logic [DispatchWidth-1:0]                alloc_req_o;
  logic [CntW-1:0]                         count_o;
  logic                                    stall_o;

  modport master (
    output fetch_valid_i, fetch_inst_i, fetch_pc_i, free_regs_i, free_rs_slots_i,
           free_rob_slots_i, flush_i,
    input  fetch_ready_o, disp_valid_o, disp_inst_o, disp_pc_o, disp_has_dest_o,
           alloc_req_o, count_o, stall_o
  );

  modport slave (
    input  fetch_valid_i, fetch_inst_i, fetch_pc_i, free_regs_i, free_rs_slots_i,
           free_rob_slots_i, flush_i,
    output fetch_ready_o, disp_valid_o, disp_inst_o, disp_pc_o, disp_has_dest_o,
           alloc_req_o, count_o, stall_o
  );
endinterface

// File: rtl/dispatch_queue_select.sv
// Combinational in-order dispatch eligibility: longest oldest-first prefix that fits.
module dispatch_queue_select #(
  parameter int unsigned DispatchWidth = 2,
  parameter int unsigned CntW          = 4,
  localparam int unsigned FreeW        = $clog2(DispatchWidth + 1)
) (
  input  logic                     block_i,
  input  logic [CntW-1:0]          count_i,
  input  logic [FreeW-1:0]         free_regs_i,
  input  logic [FreeW-1:0]         free_rs_i,
  input  logic [FreeW-1:0]         free_rob_i,
  input  logic [DispatchWidth-1:0] has_dest_i,
  output logic [DispatchWidth-1:0] valid_o,
  output logic [FreeW-1:0]         num_o
);

  // Walk lanes oldest first; the first ineligible lane blocks every younger one.
  always_comb begin
    int unsigned cnt, regs, rs, rob, dests;
    logic prev;
    valid_o = '0;
    num_o   = '0;
    prev    = 1'b1;
    dests   = 0;
    cnt     = 32'(count_i);
    // Credits above the dispatch width are clamped to it.
    regs = (32'(free_regs_i) > DispatchWidth) ? DispatchWidth : 32'(free_regs_i);
    rs   = (32'(free_rs_i) > DispatchWidth) ? DispatchWidth : 32'(free_rs_i);
    rob  = (32'(free_rob_i) > DispatchWidth) ? DispatchWidth : 32'(free_rob_i);
    for (int unsigned j = 0; j < DispatchWidth; j++) begin
      dests = dests + (has_dest_i[j] ? 32'd1 : 32'd0);
      valid_o[j] = prev && !block_i && (j < cnt) && (j < rs) && (j < rob) && (dests <= regs);
      prev = valid_o[j];
      if (valid_o[j]) num_o = num_o + FreeW'(1);
    end
  end

endmodule

// File: rtl/dispatch_queue.sv
// In-order instruction buffer between fetch and rename/dispatch.
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int unsigned FetchWidth    = 2,
  parameter int unsigned DispatchWidth = 2,
  parameter int unsigned QDepth        = 8,
  parameter int unsigned AddrWidth     = 32
) (
  input logic              clk_i,
  input logic              rst_ni,
  dispatch_queue_if.slave  bus
);

  localparam int unsigned IdxW  = $clog2(QDepth);
  localparam int unsigned PtrW  = IdxW + 1;
  localparam int unsigned CntW  = $clog2(QDepth + 1);
  localparam int unsigned FreeW = $clog2(DispatchWidth + 1);

  typedef struct packed {
    logic [31:0]          inst;
    logic [AddrWidth-1:0] pc;
    logic                 has_dest;
  } entry_t;

  entry_t                   mem_q [QDepth];
  logic [PtrW-1:0]          head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]          count_q, count_d;
  logic                     fetch_ready;
  logic [CntW-1:0]          enq_cnt;
  logic [CntW-1:0]          enq_off [FetchWidth];
  logic [DispatchWidth-1:0] cand_dest, disp_valid;
  logic [FreeW-1:0]         disp_num;
  int unsigned              avail;

  // Acceptance looks only at registered occupancy, never at this cycle's dispatch.
  assign fetch_ready = !bus.flush_i && ((CntW'(QDepth) - count_q) >= CntW'(FetchWidth));

  // Compaction offsets: each valid lane lands after the valid lanes older than it.
  always_comb begin
    enq_cnt = '0;
    for (int i = 0; i < FetchWidth; i++) begin
      enq_off[i] = enq_cnt;
      if (bus.fetch_valid_i[i]) enq_cnt = enq_cnt + CntW'(1);
    end
  end

  // Present the oldest entries from head, wrapping around the buffer.
  always_comb begin
    logic [IdxW-1:0] idx;
    for (int j = 0; j < DispatchWidth; j++) begin
      idx                    = head_q[IdxW-1:0] + IdxW'(j);
      bus.disp_inst_o[j]     = mem_q[idx].inst;
      bus.disp_pc_o[j]       = mem_q[idx].pc;
      cand_dest[j]           = mem_q[idx].has_dest;
    end
  end

  dispatch_queue_select #(
    .DispatchWidth (DispatchWidth),
    .CntW          (CntW)
  ) u_select (
    .block_i     (bus.flush_i),
    .count_i     (count_q),
    .free_regs_i (bus.free_regs_i),
    .free_rs_i   (bus.free_rs_slots_i),
    .free_rob_i  (bus.free_rob_slots_i),
    .has_dest_i  (cand_dest),
    .valid_o     (disp_valid),
    .num_o       (disp_num)
  );

  assign bus.fetch_ready_o   = fetch_ready;
  assign bus.disp_valid_o    = disp_valid;
  assign bus.disp_has_dest_o = cand_dest;
  assign bus.alloc_req_o     = disp_valid & cand_dest;
  assign bus.count_o         = count_q;

  // Stall when fewer lanes leave than the occupancy would allow.
  always_comb begin
    avail       = (32'(count_q) < DispatchWidth) ? 32'(count_q) : DispatchWidth;
    bus.stall_o = (count_q != '0) && (32'(disp_num) < avail);
  end

  // Pointer and occupancy update; flush wins over enqueue and dequeue.
  always_comb begin
    head_d  = head_q + PtrW'(disp_num);
    tail_d  = tail_q + (fetch_ready ? PtrW'(enq_cnt) : '0);
    count_d = count_q + (fetch_ready ? enq_cnt : '0) - CntW'(disp_num);
    if (bus.flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Control state with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage; contents are only meaningful between head and tail.
  always_ff @(posedge clk_i) begin
    if (fetch_ready) begin
      for (int i = 0; i < FetchWidth; i++) begin
        if (bus.fetch_valid_i[i]) begin
          mem_q[tail_q[IdxW-1:0] + IdxW'(enq_off[i])] <= '{
            inst:     bus.fetch_inst_i[i],
            pc:       bus.fetch_pc_i[i],
            has_dest: decode_has_dest(bus.fetch_inst_i[i][11:0])
          };
        end
      end
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue with a scoreboard-driven dispatch monitor.
module tb_dispatch_queue;

  localparam logic [31:0] I_ADD  = 32'h00B300B3;  // add x1 -> dest
  localparam logic [31:0] I_SW   = 32'h00552823;  // store -> no dest
  localparam logic [31:0] I_SUB  = 32'h40A60733;  // sub x14 -> dest
  localparam logic [31:0] I_SW2  = 32'h02F3A023;  // store -> no dest
  localparam logic [31:0] I_ADDI = 32'h00100093;  // addi x1 -> dest
  localparam logic [31:0] I_BEQ  = 32'h00208463;  // branch, rd field nonzero -> no dest
  localparam logic [31:0] I_ADD0 = 32'h00000033;  // add x0 -> no dest
  localparam logic [31:0] I_LW   = 32'h0002A303;  // lw x6 -> dest

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        dest;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_ni;
  int   n_vec = 0;
  int   n_fail = 0;
  exp_t sb[$];

  logic [31:0] t4_inst [8];
  logic        t4_dest [8];

  always #5 clk_i = ~clk_i;

  dispatch_queue_if #(
    .FetchWidth(2), .DispatchWidth(2), .QDepth(8), .AddrWidth(32)
  ) bus ();

  dispatch_queue #(
    .FetchWidth(2), .DispatchWidth(2), .QDepth(8), .AddrWidth(32)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_free(input int r, input int rs, input int rob);
    bus.free_regs_i      = 2'(r);
    bus.free_rs_slots_i  = 2'(rs);
    bus.free_rob_slots_i = 2'(rob);
  endtask

  task automatic idle();
    bus.fetch_valid_i = '0;
  endtask

  // Drive one bundle; when it should be accepted, queue the valid lanes in order.
  task automatic fetch(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] p0,
                       input logic d0, input logic [31:0] i1, input logic [31:0] p1,
                       input logic d1, input logic acc);
    bus.fetch_valid_i   = v;
    bus.fetch_inst_i[0] = i0;
    bus.fetch_pc_i[0]   = p0;
    bus.fetch_inst_i[1] = i1;
    bus.fetch_pc_i[1]   = p1;
    #1;
    chk("fetch_ready", 64'(bus.fetch_ready_o), 64'(acc));
    if (acc) begin
      if (v[0]) sb.push_back('{inst: i0, pc: p0, dest: d0});
      if (v[1]) sb.push_back('{inst: i1, pc: p1, dest: d1});
    end
  endtask

  // Monitor: every dispatched lane must match the next expected instruction.
  always @(negedge clk_i) begin
    logic gap;
    exp_t e;
    if (rst_ni) begin
      gap = 1'b0;
      for (int j = 0; j < 2; j++) begin
        if (bus.disp_valid_o[j]) begin
          chk("disp_prefix", 64'(gap), 64'(0));
          if (sb.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL sb_underflow: lane %0d dispatched pc %0h with nothing expected",
                     j, bus.disp_pc_o[j]);
          end else begin
            e = sb.pop_front();
            chk("disp_inst", 64'(bus.disp_inst_o[j]), 64'(e.inst));
            chk("disp_pc", 64'(bus.disp_pc_o[j]), 64'(e.pc));
            chk("disp_has_dest", 64'(bus.disp_has_dest_o[j]), 64'(e.dest));
            chk("alloc_req", 64'(bus.alloc_req_o[j]), 64'(e.dest));
          end
        end else begin
          gap = 1'b1;
        end
      end
    end
  end

  initial begin
    t4_inst[0] = I_ADDI; t4_dest[0] = 1'b1;
    t4_inst[1] = I_BEQ;  t4_dest[1] = 1'b0;
    t4_inst[2] = I_ADD0; t4_dest[2] = 1'b0;
    t4_inst[3] = I_LW;   t4_dest[3] = 1'b1;
    t4_inst[4] = I_ADDI; t4_dest[4] = 1'b1;
    t4_inst[5] = I_LW;   t4_dest[5] = 1'b1;
    t4_inst[6] = I_BEQ;  t4_dest[6] = 1'b0;
    t4_inst[7] = I_ADD0; t4_dest[7] = 1'b0;

    rst_ni       = 1'b0;
    bus.flush_i  = 1'b0;
    bus.fetch_inst_i = '0;
    bus.fetch_pc_i   = '0;
    idle();
    set_free(2, 2, 2);
    #2;
    chk("rst_count", 64'(bus.count_o), 64'(0));
    chk("rst_disp_valid", 64'(bus.disp_valid_o), 64'(0));
    chk("rst_alloc", 64'(bus.alloc_req_o), 64'(0));
    chk("rst_stall", 64'(bus.stall_o), 64'(0));
    chk("rst_fetch_ready", 64'(bus.fetch_ready_o), 64'(1));
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // 1: full-width dispatch of ADD + SW
    fetch(2'b11, I_ADD, 32'h1000, 1'b1, I_SW, 32'h1004, 1'b0, 1'b1);
    chk("t1_count_before", 64'(bus.count_o), 64'(0));
    tick(); idle(); #1;
    chk("t1_count", 64'(bus.count_o), 64'(2));
    chk("t1_valid", 64'(bus.disp_valid_o), 64'(2'b11));
    chk("t1_has_dest", 64'(bus.disp_has_dest_o), 64'(2'b01));
    chk("t1_alloc", 64'(bus.alloc_req_o), 64'(2'b01));
    chk("t1_stall", 64'(bus.stall_o), 64'(0));
    tick(); #1;
    chk("t1_drained", 64'(bus.count_o), 64'(0));

    // 2: no free regs blocks the ADD and the SW behind it
    set_free(0, 2, 2);
    fetch(2'b11, I_ADD, 32'h1100, 1'b1, I_SW, 32'h1104, 1'b0, 1'b1);
    tick(); idle(); #1;
    chk("t2_valid_blocked", 64'(bus.disp_valid_o), 64'(0));
    chk("t2_stall", 64'(bus.stall_o), 64'(1));
    chk("t2_count", 64'(bus.count_o), 64'(2));
    tick(); #1;
    chk("t2_count_held", 64'(bus.count_o), 64'(2));
    set_free(1, 2, 2); #1;
    chk("t2_valid_one_reg", 64'(bus.disp_valid_o), 64'(2'b11));
    chk("t2_stall_clear", 64'(bus.stall_o), 64'(0));
    tick(); #1;
    chk("t2_drained", 64'(bus.count_o), 64'(0));

    // 3: one ROB slot lets only the SUB through
    set_free(2, 2, 1);
    fetch(2'b11, I_SUB, 32'h2000, 1'b1, I_SW2, 32'h2004, 1'b0, 1'b1);
    tick(); idle(); #1;
    chk("t3_valid", 64'(bus.disp_valid_o), 64'(2'b01));
    chk("t3_stall", 64'(bus.stall_o), 64'(1));
    chk("t3_count", 64'(bus.count_o), 64'(2));
    tick(); #1;
    chk("t3_count_one", 64'(bus.count_o), 64'(1));
    chk("t3_valid_sw", 64'(bus.disp_valid_o), 64'(2'b01));
    chk("t3_stall_clear", 64'(bus.stall_o), 64'(0));
    tick(); #1;
    chk("t3_drained", 64'(bus.count_o), 64'(0));

    // 4: fill to full with credits withheld, then drain across the wrap
    set_free(0, 0, 0);
    for (int b = 0; b < 4; b++) begin
      fetch(2'b11, t4_inst[2*b], 32'h3000 + 32'(8*b), t4_dest[2*b],
            t4_inst[2*b+1], 32'h3004 + 32'(8*b), t4_dest[2*b+1], 1'b1);
      chk("t4_fill_count", 64'(bus.count_o), 64'(2*b));
      tick();
    end
    fetch(2'b11, I_ADD, 32'h3100, 1'b1, I_ADD, 32'h3104, 1'b1, 1'b0);
    chk("t4_full_count", 64'(bus.count_o), 64'(8));
    chk("t4_full_stall", 64'(bus.stall_o), 64'(1));
    tick(); idle(); #1;
    chk("t4_not_enqueued", 64'(bus.count_o), 64'(8));
    set_free(2, 2, 2);
    for (int r = 0; r < 4; r++) begin
      #1;
      chk("t4_drain_count", 64'(bus.count_o), 64'(8 - 2*r));
      chk("t4_drain_valid", 64'(bus.disp_valid_o), 64'(2'b11));
      tick();
    end
    #1;
    chk("t4_drained", 64'(bus.count_o), 64'(0));

    // 5: only lane 1 valid is compacted into a single entry
    fetch(2'b10, 32'hFFFFFFFF, 32'h4000, 1'b0, I_ADDI, 32'h4004, 1'b1, 1'b1);
    tick(); idle(); #1;
    chk("t5_count", 64'(bus.count_o), 64'(1));
    chk("t5_valid", 64'(bus.disp_valid_o), 64'(2'b01));
    chk("t5_pc0", 64'(bus.disp_pc_o[0]), 64'(32'h4004));
    tick(); #1;
    chk("t5_drained", 64'(bus.count_o), 64'(0));

    // 6a: flush with five entries queued and a valid fetch alongside
    set_free(0, 0, 0);
    fetch(2'b11, I_ADD, 32'h5000, 1'b1, I_SW, 32'h5004, 1'b0, 1'b1);
    tick();
    fetch(2'b11, I_SUB, 32'h5008, 1'b1, I_LW, 32'h500C, 1'b1, 1'b1);
    tick();
    fetch(2'b10, I_ADD, 32'h5010, 1'b1, I_BEQ, 32'h5014, 1'b0, 1'b1);
    tick(); idle(); #1;
    chk("t6_count5", 64'(bus.count_o), 64'(5));
    bus.flush_i = 1'b1;
    set_free(2, 2, 2);
    fetch(2'b11, I_ADD, 32'h5100, 1'b1, I_ADD, 32'h5104, 1'b1, 1'b0);
    chk("t6_flush_valid", 64'(bus.disp_valid_o), 64'(0));
    chk("t6_flush_alloc", 64'(bus.alloc_req_o), 64'(0));
    tick();
    sb.delete();
    bus.flush_i = 1'b0;
    idle(); #1;
    chk("t6_flush_count", 64'(bus.count_o), 64'(0));
    chk("t6_flush_empty_valid", 64'(bus.disp_valid_o), 64'(0));

    // 6b: asynchronous reset in the middle of a drain
    set_free(0, 0, 0);
    fetch(2'b11, I_ADD, 32'h6000, 1'b1, I_SW, 32'h6004, 1'b0, 1'b1);
    tick();
    fetch(2'b11, I_SUB, 32'h6008, 1'b1, I_LW, 32'h600C, 1'b1, 1'b1);
    tick(); idle();
    set_free(2, 2, 2); #1;
    chk("t6_pre_count", 64'(bus.count_o), 64'(4));
    chk("t6_pre_valid", 64'(bus.disp_valid_o), 64'(2'b11));
    tick(); #1;
    chk("t6_mid_count", 64'(bus.count_o), 64'(2));
    chk("t6_mid_valid", 64'(bus.disp_valid_o), 64'(2'b11));
    #1 rst_ni = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(bus.disp_valid_o), 64'(0));
    chk("t6_rst_alloc", 64'(bus.alloc_req_o), 64'(0));
    chk("t6_rst_count", 64'(bus.count_o), 64'(0));
    chk("t6_rst_stall", 64'(bus.stall_o), 64'(0));
    chk("t6_rst_ready", 64'(bus.fetch_ready_o), 64'(1));
    sb.delete();
    tick();
    rst_ni = 1'b1;
    tick(); #1;
    chk("t6_post_count", 64'(bus.count_o), 64'(0));
    chk("sb_leftover", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
